range_enum: RTL and testbench

RANGE_ENUM -- requirements
Module: range_enum

---
 rtl/range_enum_pkg.sv | 14 +
 rtl/range_step.sv | 38 +++
 rtl/range_enum.sv | 148 ++++++++++++++
 tb/tb_range_enum.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_enum_pkg.sv
// Shared types and default widths for the range enumerator.
package range_enum_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_COUNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIMED = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/range_step.sv
// Successor of an element and whether that successor lies past the end of the range.
module range_step
    import range_enum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] value,
    input  logic signed [WIDTH-1:0] step,
    input  logic signed [WIDTH-1:0] last,
    output logic signed [WIDTH-1:0] next,
    output logic                    past_end
);

    logic signed [WIDTH:0] sum_w;
    logic signed [WIDTH:0] last_w;
    logic                  step_pos;
    logic                  step_neg;

    always_comb begin
        sum_w    = {value[WIDTH-1], value} + {step[WIDTH-1], step};
        last_w   = {last[WIDTH-1], last};
        step_neg = step[WIDTH-1];
        step_pos = !step[WIDTH-1] && (step != '0);
        next     = sum_w[WIDTH-1:0];
        past_end = 1'b0;
        // A zero step never advances, so the start value is the whole range.
        if (sum_w[WIDTH] != sum_w[WIDTH-1]) begin
            past_end = 1'b1;
        end else if (step_pos && (sum_w > last_w)) begin
            past_end = 1'b1;
        end else if (step_neg && (sum_w < last_w)) begin
            past_end = 1'b1;
        end else if (!step_pos && !step_neg) begin
            past_end = 1'b1;
        end
    end

endmodule

// File: rtl/range_enum.sv
// Steps through first, first+step, ... up to last, one element per request edge.
module range_enum
    import range_enum_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int CYCLIC  = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ready,
    input  logic signed [WIDTH-1:0]   first,
    input  logic signed [WIDTH-1:0]   last,
    input  logic signed [WIDTH-1:0]   step,
    input  logic                      req,
    output logic                      ack,
    output logic                      eol,
    output logic signed [WIDTH-1:0]   value,
    output logic [COUNT_W-1:0]        index,
    output logic                      wrap
);

    state_e                   state_q, state_d;
    logic signed [WIDTH-1:0]  first_q, first_d;
    logic signed [WIDTH-1:0]  last_q, last_d;
    logic signed [WIDTH-1:0]  step_q, step_d;
    logic signed [WIDTH-1:0]  value_q, value_d;
    logic signed [WIDTH-1:0]  nxt_q, nxt_d;
    logic [COUNT_W-1:0]       index_q, index_d;
    logic                     req_q;
    logic                     ack_q, ack_d;
    logic                     wrap_q, wrap_d;
    logic                     wrap_pend_q, wrap_pend_d;

    logic                     step_pos;
    logic                     step_neg;
    logic                     empty;
    logic                     accept;
    logic signed [WIDTH-1:0]  emit_val;
    logic signed [WIDTH-1:0]  succ;
    logic                     final_el;

    localparam logic [COUNT_W-1:0] IDX_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    assign step_pos = !step_q[WIDTH-1] && (step_q != '0);
    assign step_neg = step_q[WIDTH-1];
    assign empty    = (step_pos && (first_q > last_q)) || (step_neg && (first_q < last_q));
    assign accept   = req && !req_q && ready && (state_q != ST_IDLE);

    // The step unit always looks at the element about to be emitted, so its
    // past_end result says whether that element is the final one.
    assign emit_val = ((state_q == ST_PRIMED) || wrap_pend_q) ? first_q : nxt_q;

    range_step #(.WIDTH(WIDTH)) u_step (
        .value    (emit_val),
        .step     (step_q),
        .last     (last_q),
        .next     (succ),
        .past_end (final_el)
    );

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        last_d      = last_q;
        step_d      = step_q;
        value_d     = value_q;
        nxt_d       = nxt_q;
        index_d     = index_q;
        wrap_pend_d = wrap_pend_q;
        ack_d       = 1'b0;
        wrap_d      = 1'b0;

        if (!ready) begin
            state_d     = ST_IDLE;
            value_d     = '0;
            index_d     = '0;
            wrap_pend_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PRIMED;
                    first_d = first;
                    last_d  = last;
                    step_d  = step;
                end
                ST_PRIMED, ST_ACTIVE: begin
                    if (accept && !(state_q == ST_PRIMED && empty)) begin
                        value_d = emit_val;
                        nxt_d   = succ;
                        ack_d   = 1'b1;
                        if (state_q == ST_PRIMED || wrap_pend_q) begin
                            index_d = '0;
                            wrap_d  = wrap_pend_q;
                        end else if (index_q != '1) begin
                            index_d = index_q + IDX_ONE;
                        end
                        if (!final_el) begin
                            state_d     = ST_ACTIVE;
                            wrap_pend_d = 1'b0;
                        end else if (CYCLIC != 0) begin
                            state_d     = ST_ACTIVE;
                            wrap_pend_d = 1'b1;
                        end else begin
                            state_d     = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            first_q     <= '0;
            last_q      <= '0;
            step_q      <= '0;
            value_q     <= '0;
            nxt_q       <= '0;
            index_q     <= '0;
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            last_q      <= last_d;
            step_q      <= step_d;
            value_q     <= value_d;
            nxt_q       <= nxt_d;
            index_q     <= index_d;
            req_q       <= req;
            ack_q       <= ack_d;
            wrap_q      <= wrap_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    assign ack   = ack_q;
    assign wrap  = wrap_q;
    assign value = value_q;
    assign index = index_q;
    assign eol   = (state_q == ST_DONE) || ((state_q == ST_PRIMED) && empty);

endmodule

// File: tb/tb_range_enum.sv
// Bench for range_enum: a terminating and a cyclic instance against a list-based reference model.
module tb_range_enum;

    localparam int W  = 8;
    localparam int CW = 16;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 ready;
    logic                 req;
    logic signed [W-1:0]  first, last, step;

    logic                 ack0, eol0, wrap0, ack1, eol1, wrap1;
    logic signed [W-1:0]  value0, value1;
    logic [CW-1:0]        index0, index1;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: the whole range as a list, plus a read position per instance
    int  seq[$];
    bit  m_cfg, m_prev;
    int  m_pos[2], m_val[2], m_idx[2];
    bit  m_done[2], m_ack[2], m_wrap[2];

    int  acks0[$], acks1[$], idx1[$];
    int  wraps1;

    always #5 clock = ~clock;

    range_enum #(.WIDTH(W), .COUNT_W(CW), .CYCLIC(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .ready(ready), .first(first), .last(last),
        .step(step), .req(req), .ack(ack0), .eol(eol0), .value(value0), .index(index0),
        .wrap(wrap0)
    );

    range_enum #(.WIDTH(W), .COUNT_W(CW), .CYCLIC(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .ready(ready), .first(first), .last(last),
        .step(step), .req(req), .ack(ack1), .eol(eol1), .value(value1), .index(index1),
        .wrap(wrap1)
    );

    task automatic check(string tag, int obs, int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_list(string tag, input int got[$], input int exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
    endtask

    function automatic void build_seq(int f, int l, int s);
        int v;
        seq.delete();
        if (s == 0) begin
            seq.push_back(f);
            return;
        end
        v = f;
        while (v >= -(1 << (W-1)) && v < (1 << (W-1)) && ((s > 0) ? (v <= l) : (v >= l))) begin
            seq.push_back(v);
            v = v + s;
        end
    endfunction

    function automatic void model_reset();
        m_cfg  = 1'b0;
        m_prev = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_pos[m] = 0; m_val[m] = 0; m_idx[m] = 0;
            m_done[m] = 1'b0; m_ack[m] = 1'b0; m_wrap[m] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit acc;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            m_ack[m] = 1'b0;
            m_wrap[m] = 1'b0;
        end
        if (!ready) begin
            m_cfg = 1'b0;
            for (int m = 0; m < 2; m++) begin
                m_val[m] = 0; m_idx[m] = 0; m_pos[m] = 0; m_done[m] = 1'b0;
            end
        end else if (!m_cfg) begin
            build_seq(int'(first), int'(last), int'(step));
            m_cfg = 1'b1;
            for (int m = 0; m < 2; m++) begin
                m_pos[m] = 0; m_done[m] = 1'b0;
            end
        end else begin
            acc = req && !m_prev;
            for (int m = 0; m < 2; m++) begin
                if (acc && seq.size() > 0 && !m_done[m]) begin
                    if (m_pos[m] == seq.size()) begin
                        m_pos[m] = 0;
                        m_wrap[m] = 1'b1;
                    end
                    m_val[m] = seq[m_pos[m]];
                    m_idx[m] = m_pos[m];
                    m_ack[m] = 1'b1;
                    m_pos[m]++;
                    if (m_pos[m] == seq.size() && m == 0) m_done[m] = 1'b1;
                end
            end
        end
        m_prev = req;
    endfunction

    function automatic int model_eol(int m);
        return int'(m_cfg && (m_done[m] || seq.size() == 0));
    endfunction

    task automatic compare_all();
        check("ack0",   int'(ack0),   int'(m_ack[0]));
        check("wrap0",  int'(wrap0),  int'(m_wrap[0]));
        check("eol0",   int'(eol0),   model_eol(0));
        check("value0", int'(value0), m_val[0]);
        check("index0", int'(index0), m_idx[0]);
        check("ack1",   int'(ack1),   int'(m_ack[1]));
        check("wrap1",  int'(wrap1),  int'(m_wrap[1]));
        check("eol1",   int'(eol1),   model_eol(1));
        check("value1", int'(value1), m_val[1]);
        check("index1", int'(index1), m_idx[1]);
        if (ack0) acks0.push_back(int'(value0));
        if (ack1) begin
            acks1.push_back(int'(value1));
            idx1.push_back(int'(index1));
        end
        if (wrap1) wraps1++;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic configure(int f, int l, int s);
        ready = 1'b0;
        tick();
        first = W'(f);
        last  = W'(l);
        step  = W'(s);
        ready = 1'b1;
        tick();
        acks0.delete();
        acks1.delete();
        idx1.delete();
        wraps1 = 0;
    endtask

    task automatic pulse_req(int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b1;
            tick();
            req = 1'b0;
            tick();
        end
    endtask

    initial begin
        int e[$];
        reset_n = 1'b0;
        ready   = 1'b0;
        req     = 1'b0;
        first   = '0;
        last    = '0;
        step    = '0;
        model_reset();
        #2;
        compare_all();
        tick();
        tick();
        reset_n = 1'b1;

        // ascending, terminating at 4
        configure(-2, 4, 3);
        pulse_req(4);
        e = '{-2, 1, 4};
        check_list("asc_vals", acks0, e);
        check("asc_eol", int'(eol0), 1);

        // descending with cyclic restart
        configure(5, -1, -2);
        pulse_req(5);
        e = '{5, 3, 1, -1, 5};
        check_list("cyc_vals", acks1, e);
        e = '{0, 1, 2, 3, 0};
        check_list("cyc_idx", idx1, e);
        check("cyc_wraps", wraps1, 1);

        // overflow ends the range after one element
        configure(120, 127, 10);
        pulse_req(3);
        e = '{120};
        check_list("ovf_vals", acks0, e);

        // empty range
        configure(3, 1, 1);
        check("empty_eol", int'(eol0), 1);
        pulse_req(2);
        check("empty_n0", acks0.size(), 0);
        check("empty_n1", acks1.size(), 0);

        // zero step
        configure(7, 0, 0);
        pulse_req(2);
        e = '{7};
        check_list("zstep_vals", acks0, e);

        // operand changes while active are ignored; ready drop restarts
        configure(0, 2, 1);
        pulse_req(2);
        first = 8'sd50;
        last  = -8'sd50;
        step  = -8'sd7;
        pulse_req(1);
        e = '{0, 1, 2};
        check_list("hold_vals", acks0, e);
        configure(0, 2, 1);
        pulse_req(1);
        e = '{0};
        check_list("restart_vals", acks0, e);
        check("restart_idx", int'(index0), 0);

        // req already high when ready rises is not an edge
        ready = 1'b0;
        req   = 1'b1;
        tick();
        ready = 1'b1;
        acks0.delete();
        tick();
        tick();
        tick();
        check("held_req_n", acks0.size(), 0);
        req = 1'b0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 9) == 0) begin
                first = W'($urandom_range(0, 255));
                last  = W'($urandom_range(0, 255));
                step  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                    : W'(int'($urandom_range(0, 6)) - 3);
            end
            if ($urandom_range(0, 2) != 0) req = ~req;
            tick();
        end

        // asynchronous reset in the middle of an enumeration
        req = 1'b0;
        configure(-10, 100, 7);
        pulse_req(2);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_value", int'(value0), 0);
        check("rst_ack", int'(ack0), 0);
        #2;
        reset_n = 1'b1;
        tick();
        pulse_req(1);
        e = '{-10};
        acks0.delete();
        pulse_req(1);
        e = '{-3};
        check_list("post_rst", acks0, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
